snitch_sim_ctrl: RTL and testbench
==================================

Name: snitch_sim_ctrl

Overview:
- Parametrised, cycle-driven simulation controller instantiated inside the testbench top, clocked by the testbench clock.
- Generates a configurable multi-pulse reset sequence for the harness and a periodic host-poll strobe.
- Captures per-hart HTIF-style exit words and raises done with an aggregated exit code.
- Watchdog aborts runs that hang.
- Generalises the fixed single-program flow to N harts, programmable reset shape, poll period and timeout.

Parameters:
- NrHarts, 1, number of monitored harts (1..32).
- HartMask, '1 (NrHarts bits), harts that must report exit before done; unmasked harts are ignored.
- NrRstPulses, 2, number of low pulses in the reset sequence (>=1).
- RstLowCycles, 5, cycles sim_rst_no is held low per pulse (>=1).
- RstHighCycles, 5, cycles sim_rst_no is held high between pulses (>=1).
- PollCycles, 100, period of poll_o in RUN (>=1).
- TimeoutCycles, 0, watchdog limit in RUN cycles; 0 disables.
- CntWidth, 32, width of internal counters.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- exit_valid_i  in  NrHarts  per-hart tohost write strobe
- exit_data_i  in  NrHarts x 32  per-hart tohost write data
- sim_rst_no  out  1  generated active-low reset to the harness
- poll_o  out  1  one-cycle host-poll strobe
- hart_done_o  out  NrHarts  sticky per-hart exit captured
- done_o  out  1  run finished (sticky)
- timeout_o  out  1  watchdog fired (sticky)
- exit_code_o  out  31  aggregated exit code

Behaviour:
- Reset values: sim_rst_no=0, poll_o=0, hart_done_o=0, done_o=0, timeout_o=0, exit_code_o=0, state=RST_LOW, pulse count=0, all counters=0.
- FSM states: RST_LOW, RST_HIGH, RUN, DONE, TIMEOUT.
  - RST_LOW: sim_rst_no=0 for RstLowCycles cycles.
    - If the pulse count is below NrRstPulses-1, go to RST_HIGH.
    - Otherwise go to RUN.
  - RST_HIGH: sim_rst_no=1 for RstHighCycles cycles, then increment the pulse count and go to RST_LOW.
  - RUN, DONE and TIMEOUT: sim_rst_no=1.
- Defaults give low 5, high 5, low 5, then high for good.
- Exit capture, RUN only:
  - Exit detection: exit_valid_i[h]=1 with exit_data_i[h][0]=1.
  - Code is exit_data_i[h][31:1], registered.
  - hart_done_o[h] is set the next cycle.
- Exit ignore rules:
  - Bit0=0 writes (syscalls) are ignored.
  - Second and later exits of the same hart are ignored.
  - Exits outside RUN are ignored.
- Done:
  - Transition to DONE in the cycle after (hart_done | newly captured) covers HartMask.
  - done_o=1 from the first DONE cycle.
  - All harts exiting in the same cycle means one-cycle latency to done_o.
- exit_code_o:
  - Valid when done_o=1.
  - Equals the captured code of the lowest-index masked hart with a nonzero code, else 0.
  - Held stable in DONE.
- poll_o:
  - Pulses one cycle every PollCycles cycles in RUN; the first pulse is on the PollCycles-th RUN cycle.
  - Never pulses in other states.
- Watchdog:
  - Counts RUN cycles.
  - When the count reaches TimeoutCycles (nonzero), go to TIMEOUT with timeout_o=1, done_o=1, exit_code_o=31'h7FFF_FFFF.
  - Completing exit and timeout in the same cycle: exit wins, go to DONE with timeout_o=0.
- DONE and TIMEOUT are terminal until rst_ni.
- Counters saturate rather than wrap.
- rst_ni asserted mid-operation asynchronously returns every register to its reset value and restarts the reset sequence.

Decomposition:
- Package snitch_sim_ctrl_pkg holds:
  - state enum sim_state_e.
  - ExitCodeWidth=31.
  - TimeoutCode=31'h7FFF_FFFF.
  - Exit-word field helpers: is_exit(), exit_code().
- One sub-module, snitch_sim_ctrl_cnt:
  - CntWidth-parameterised up-counter with clear, enable and terminal-count compare against a runtime limit, saturating.
  - Instantiated three times: reset-phase, poll and watchdog.

Test Plan:
- Defaults, no stimulus: sim_rst_no low cycles 0-4, high 5-9, low 10-14, high from 15; poll_o pulses at RUN cycle 100, 200, 300.
- NrHarts=4, harts 0-3 write 32'h1 at cycles 40, 55, 70, 90 after RUN → hart_done_o fills bitwise; done_o=1 at cycle 91; exit_code_o=0.
- NrHarts=4, hart2 writes 32'h7 (code 3) and hart1 writes 32'hB (code 5), others write 32'h1 → exit_code_o=5 (hart1 is the lowest-index nonzero); a hart0 rewrite of 32'h3 is ignored.
- Syscall word 32'h8000_0000 on hart0, then 32'h1 → only the second write sets hart_done_o[0]; HartMask=4'b0101 → done after harts 0 and 2 only.
- TimeoutCycles=500, no exits → TIMEOUT at RUN cycle 500: timeout_o=1, done_o=1, exit_code_o=31'h7FFF_FFFF; last hart exits in the same cycle as the 500th → DONE, timeout_o=0.
- rst_ni pulsed low at RUN cycle 30 after two harts are done → all outputs zero immediately; reset sequence replays; hart_done_o=0 afterwards.

Source files
------------

// File: rtl/snitch_sim_ctrl_pkg.sv
// snitch_sim_ctrl_pkg: controller states, exit-code constants and tohost word helpers
package snitch_sim_ctrl_pkg;
  typedef enum logic [2:0] {RST_LOW, RST_HIGH, RUN, DONE, TIMEOUT} sim_state_e;
  localparam int ExitCodeWidth = 31;
  localparam logic [ExitCodeWidth-1:0] TimeoutCode = 31'h7FFF_FFFF;
  function automatic logic is_exit(input logic [31:0] word);
    return word[0];
  endfunction
  function automatic logic [ExitCodeWidth-1:0] exit_code(input logic [31:0] word);
    return word[31:1];
  endfunction
endpackage

// File: rtl/snitch_sim_ctrl_cnt.sv
// snitch_sim_ctrl_cnt: saturating up-counter with clear, enable and terminal-count compare
module snitch_sim_ctrl_cnt #(
  parameter int CntWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic [CntWidth-1:0] limit_i,
  output logic                tc_o
);
  logic [CntWidth-1:0] cnt_d, cnt_q;
  // clear wins; otherwise count enabled cycles and stick at all-ones
  always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != '1) ? cnt_q + CntWidth'(1) : cnt_q;
  // count register
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  // high during the limit-th enabled cycle since the last clear
  assign tc_o = cnt_q >= limit_i - CntWidth'(1);
endmodule

// File: rtl/snitch_sim_ctrl.sv
// snitch_sim_ctrl: harness reset sequencer, host-poll strobe, per-hart exit capture and watchdog
module snitch_sim_ctrl import snitch_sim_ctrl_pkg::*; #(
  parameter int                 NrHarts       = 1,
  parameter logic [NrHarts-1:0] HartMask      = '1,
  parameter int                 NrRstPulses   = 2,
  parameter int                 RstLowCycles  = 5,
  parameter int                 RstHighCycles = 5,
  parameter int                 PollCycles    = 100,
  parameter int                 TimeoutCycles = 0,
  parameter int                 CntWidth      = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NrHarts-1:0]            exit_valid_i,
  input  logic [NrHarts-1:0][31:0]      exit_data_i,
  output logic                          sim_rst_no,
  output logic                          poll_o,
  output logic [NrHarts-1:0]            hart_done_o,
  output logic                          done_o,
  output logic                          timeout_o,
  output logic [ExitCodeWidth-1:0]      exit_code_o
);
  sim_state_e state_d, state_q;
  logic [CntWidth-1:0] pulse_d, pulse_q;
  logic [NrHarts-1:0] hart_done_d, hart_done_q, new_exit;
  logic [NrHarts-1:0][ExitCodeWidth-1:0] code_d, code_q;
  logic [ExitCodeWidth-1:0] agg_code;
  logic run, in_rst, phase_tc, poll_tc, wd_tc, wd_fire, all_done;
  assign run    = state_q == RUN;
  assign in_rst = state_q == RST_LOW || state_q == RST_HIGH;
  snitch_sim_ctrl_cnt #(.CntWidth(CntWidth)) i_phase_cnt (
    .clk_i, .rst_ni, .clr_i(phase_tc), .en_i(in_rst),
    .limit_i(state_q == RST_HIGH ? CntWidth'(RstHighCycles) : CntWidth'(RstLowCycles)),
    .tc_o(phase_tc)
  );
  snitch_sim_ctrl_cnt #(.CntWidth(CntWidth)) i_poll_cnt (
    .clk_i, .rst_ni, .clr_i(poll_o), .en_i(run), .limit_i(CntWidth'(PollCycles)), .tc_o(poll_tc)
  );
  snitch_sim_ctrl_cnt #(.CntWidth(CntWidth)) i_wd_cnt (
    .clk_i, .rst_ni, .clr_i(1'b0), .en_i(run), .limit_i(CntWidth'(TimeoutCycles)), .tc_o(wd_tc)
  );
  assign poll_o  = run && poll_tc;
  assign wd_fire = run && TimeoutCycles != 0 && wd_tc;
  // first terminating tohost write per hart while running; syscalls and repeats are dropped
  always_comb begin
    hart_done_d = hart_done_q;
    code_d      = code_q;
    new_exit    = '0;
    for (int h = 0; h < NrHarts; h++) begin
      new_exit[h] = run && exit_valid_i[h] && is_exit(exit_data_i[h]) && !hart_done_q[h];
      if (new_exit[h]) begin
        hart_done_d[h] = 1'b1;
        code_d[h]      = exit_code(exit_data_i[h]);
      end
    end
  end
  assign all_done = ((hart_done_q | new_exit) & HartMask) == HartMask;
  // reset-pulse sequencing, then run until the masked harts exit or the watchdog fires
  always_comb begin
    state_d = state_q;
    pulse_d = pulse_q;
    case (state_q)
      RST_LOW:  if (phase_tc) state_d = pulse_q < CntWidth'(NrRstPulses - 1) ? RST_HIGH : RUN;
      RST_HIGH: if (phase_tc) begin
        state_d = RST_LOW;
        pulse_d = pulse_q != '1 ? pulse_q + CntWidth'(1) : pulse_q;
      end
      RUN:      state_d = all_done ? DONE : wd_fire ? TIMEOUT : RUN;
      default:  state_d = state_q;
    endcase
  end
  // lowest-index masked hart with a nonzero code decides the run result
  always_comb begin
    agg_code = '0;
    for (int h = NrHarts - 1; h >= 0; h--)
      if (HartMask[h] && code_q[h] != '0) agg_code = code_q[h];
  end
  // state, pulse count and captured exits
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q     <= RST_LOW;
      pulse_q     <= '0;
      hart_done_q <= '0;
      code_q      <= '0;
    end else begin
      state_q     <= state_d;
      pulse_q     <= pulse_d;
      hart_done_q <= hart_done_d;
      code_q      <= code_d;
    end
  assign sim_rst_no  = state_q != RST_LOW;
  assign hart_done_o = hart_done_q;
  assign done_o      = state_q == DONE || state_q == TIMEOUT;
  assign timeout_o   = state_q == TIMEOUT;
  assign exit_code_o = state_q == TIMEOUT ? TimeoutCode : state_q == DONE ? agg_code : '0;
endmodule

// File: tb/tb_snitch_sim_ctrl.sv
// tb_snitch_sim_ctrl: planned random/directed runs, event scoreboard against a plan-level model
module tb_snitch_sim_ctrl;
  localparam int NH = 4, NR = 2, L = 5, H = 5, P = 100, TO = 500, MAXC = 1200;
  localparam int RS = NR * L + (NR - 1) * H;
  localparam logic [NH-1:0] MASK = 4'b1011;
  typedef struct { int c; int k; logic [63:0] v; } ev_t;
  logic clk, rst_ni, sim_rst_no, poll_o, done_o, timeout_o;
  logic [NH-1:0] exit_valid, hart_done_o;
  logic [NH-1:0][31:0] exit_data;
  logic [30:0] exit_code_o;
  ev_t exp_q[$];
  logic ev_v [MAXC][NH];
  logic [31:0] ev_d [MAXC][NH];
  int cyc = 0, n_checks = 0, n_errors = 0;
  bit mon_en = 0, rst_chk = 0;
  snitch_sim_ctrl #(.NrHarts(NH), .HartMask(MASK), .NrRstPulses(NR), .RstLowCycles(L),
    .RstHighCycles(H), .PollCycles(P), .TimeoutCycles(TO), .CntWidth(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .exit_valid_i(exit_valid), .exit_data_i(exit_data),
    .sim_rst_no(sim_rst_no), .poll_o(poll_o), .hart_done_o(hart_done_o), .done_o(done_o),
    .timeout_o(timeout_o), .exit_code_o(exit_code_o));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #1_000_000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1);
  end
  function automatic string kname(input int k);
    return k == 0 ? "sim_rst" : k == 1 ? "poll" : k == 2 ? "hart_done" : "done";
  endfunction
  task automatic push(input int c, input int k, input logic [63:0] v);
    ev_t e;
    e.c = c; e.k = k; e.v = v;
    exp_q.push_back(e);
  endtask
  task automatic clear_plan();
    for (int c = 0; c < MAXC; c++)
      for (int h = 0; h < NH; h++) begin
        ev_v[c][h] = 0; ev_d[c][h] = 0;
      end
  endtask
  task automatic put(input int c, input int h, input logic [31:0] d);
    ev_v[c][h] = 1; ev_d[c][h] = d;
  endtask
  // expected output events of a whole run, derived from the exit plan
  task automatic build_exp(input int last);
    int cap [NH];
    logic [30:0] code [NH];
    int term, o;
    bit all, to;
    logic [30:0] ecode;
    logic r, pr;
    logic [NH-1:0] hd, phd;
    for (int h = 0; h < NH; h++) begin
      cap[h] = -1; code[h] = 0;
      for (int c = RS; c <= last; c++)
        if (cap[h] < 0 && ev_v[c][h] && ev_d[c][h][0]) begin
          cap[h] = c - RS; code[h] = ev_d[c][h][31:1];
        end
    end
    all = 1; term = 0;
    for (int h = 0; h < NH; h++)
      if (MASK[h]) begin
        if (cap[h] < 0) all = 0;
        else if (cap[h] + 1 > term) term = cap[h] + 1;
      end
    if (!all) term = 1 << 30;
    to = TO > 0 && term > TO;
    if (to) term = TO;
    ecode = to ? 31'h7FFF_FFFF : 31'h0;
    if (!to)
      for (int h = NH - 1; h >= 0; h--)
        if (MASK[h] && cap[h] >= 0 && code[h] != 0) ecode = code[h];
    pr = 0; phd = 0;
    for (int c = 0; c <= last; c++) begin
      o = c - RS;
      r = (c >= RS) || (c % (L + H) >= L);
      if (r != pr) push(c, 0, 64'(r));
      if (o >= 0 && o < term && (o + 1) % P == 0) push(c, 1, 64'd1);
      hd = 0;
      for (int h = 0; h < NH; h++) if (cap[h] >= 0 && cap[h] < term && o > cap[h]) hd[h] = 1;
      if (hd != phd) push(c, 2, 64'(hd));
      if (o == term) push(c, 3, 64'({1'b1, to, ecode}));
      pr = r; phd = hd;
    end
  endtask
  task automatic chk_ev(input int k, input logic [63:0] v);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL unexpected_%s cyc=%0d got=%h expected=none", kname(k), cyc, v);
      return;
    end
    e = exp_q.pop_front();
    if (e.c != cyc || e.k != k || e.v !== v) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h, expected %s at cyc=%0d value=%h",
               kname(k), cyc, v, kname(e.k), e.c, e.v);
    end
  endtask
  // monitor: turns output changes into events and checks them against the scoreboard
  initial begin
    logic p_rst;
    logic [NH-1:0] p_hd;
    logic [32:0] p_dn;
    ev_t e;
    p_rst = 0; p_hd = 0; p_dn = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (cyc == 0) begin p_rst = 0; p_hd = 0; p_dn = 0; end
        if (sim_rst_no !== p_rst) chk_ev(0, 64'(sim_rst_no));
        if (poll_o !== 1'b0) chk_ev(1, 64'(poll_o));
        if (hart_done_o !== p_hd) chk_ev(2, 64'(hart_done_o));
        if ({done_o, timeout_o, exit_code_o} !== p_dn) chk_ev(3, 64'({done_o, timeout_o, exit_code_o}));
        p_rst = sim_rst_no; p_hd = hart_done_o; p_dn = {done_o, timeout_o, exit_code_o};
      end else if (rst_chk) begin
        n_checks++;
        if ({sim_rst_no, poll_o, hart_done_o, done_o, timeout_o, exit_code_o} !== '0) begin
          n_errors++;
          $display("FAIL async_reset got rst=%b poll=%b hd=%b done=%b to=%b code=%h, expected all zero",
                   sim_rst_no, poll_o, hart_done_o, done_o, timeout_o, exit_code_o);
        end
        while (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_checks++; n_errors++;
          $display("FAIL missing_%s expected at cyc=%0d value=%h got=none", kname(e.k), e.c, e.v);
        end
      end
    end
  end
  // asynchronous reset asserted between clock edges; outputs checked before any edge
  task automatic do_reset();
    @(posedge clk); #1;
    mon_en = 0; rst_ni = 0; rst_chk = 1;
    @(negedge clk); #1;
    rst_chk = 0;
    repeat (2) @(posedge clk);
  endtask
  task automatic run(input int last);
    build_exp(last);
    for (int c = 0; c <= last; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin rst_ni = 1; mon_en = 1; end
      cyc = c;
      for (int h = 0; h < NH; h++) begin
        exit_valid[h] = ev_v[c][h];
        exit_data[h]  = ev_v[c][h] ? ev_d[c][h] : $urandom;
      end
      @(negedge clk); #1;
    end
    exit_valid = '0;
    do_reset();
  endtask
  task automatic gen_random();
    int n;
    logic [31:0] d;
    clear_plan();
    for (int h = 0; h < NH; h++) begin
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
        d = $urandom;
        if ($urandom_range(0, 2) == 0) d[31:1] = 0;
        put($urandom_range(0, RS + 560), h, d);
      end
    end
  endtask
  initial begin
    rst_ni = 0; exit_valid = '0; exit_data = '0;
    do_reset();
    clear_plan();
    for (int c = 0; c < RS; c++)
      for (int h = 0; h < NH; h++) if ($urandom_range(0, 2) == 0) put(c, h, $urandom | 32'h1);
    run(RS + 505);
    clear_plan();
    put(RS + 40, 0, 32'h1); put(RS + 55, 1, 32'h1); put(RS + 70, 2, 32'h1); put(RS + 90, 3, 32'h1);
    put(RS + 95, 2, 32'hFF);
    run(RS + 100);
    clear_plan();
    put(RS + 5, 0, 32'h1); put(RS + 10, 2, 32'h7); put(RS + 20, 1, 32'hB);
    put(RS + 25, 0, 32'h3); put(RS + 30, 3, 32'h1);
    run(RS + 40);
    clear_plan();
    put(RS + 3, 0, 32'h8000_0000); put(RS + 8, 0, 32'h1); put(RS + 12, 1, 32'h1); put(RS + 15, 3, 32'h1);
    run(RS + 25);
    clear_plan();
    put(RS + 100, 0, 32'h1); put(RS + 200, 1, 32'h9); put(RS + 499, 3, 32'h1);
    run(RS + 505);
    clear_plan();
    put(RS + 5, 0, 32'h1); put(RS + 10, 1, 32'h1);
    run(RS + 30);
    for (int r = 0; r < 6; r++) begin
      gen_random();
      run(RS + 600);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
